// File: rtl/imem_loader.sv
// Byte-stream program loader for a writable instruction memory: takes a word-count
// header followed by little-endian instruction bytes and writes one imem word per 4 bytes.
module imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int N_WORDS = 2 ** ADDR_W;
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  state_t            state;
  logic [1:0]        lane;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   n_words;
  logic [23:0]       acc;
  logic [TW-1:0]     tcnt;
  logic              hs;

  assign byte_ready = (state == HDR) || (state == DATA);
  assign busy       = byte_ready;
  assign done       = (state == DONE);
  assign hs         = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lane         <= '0;
      idx          <= '0;
      tcnt         <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR;
            err          <= 1'b0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            tcnt         <= '0;
          end
        end
        HDR, DATA: begin
          if (hs) begin
            tcnt <= '0;
            if (state == HDR) begin
              // Header value 0 encodes a full-memory image.
              if (int'(byte_data) > N_WORDS) begin
                state <= ERR;
              end else begin
                n_words <= (byte_data == 8'd0) ? (ADDR_W+1)'(N_WORDS)
                                               : (ADDR_W+1)'(byte_data);
                lane    <= '0;
                idx     <= '0;
                state   <= DATA;
              end
            end else begin
              if (lane == 2'd3) begin
                imem_we      <= 1'b1;
                imem_waddr   <= idx[ADDR_W-1:0];
                imem_wdata   <= {byte_data, acc};
                idx          <= idx + (ADDR_W+1)'(1);
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
                if (idx == n_words - (ADDR_W+1)'(1)) state <= DONE;
              end else begin
                acc[{lane, 3'b000} +: 8] <= byte_data;
              end
              lane <= lane + 2'd1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Stalled link: drop any partially assembled word.
            state <= ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-count reference model plus directed and random loads.
module tb_imem_loader;
  localparam int AW = 6;
  localparam int NW = 64;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [AW:0] words_loaded;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: tracks bytes consumed in the current load rather than lanes/states.
  bit          loading = 0, fin = 0, errp = 0;
  int          nb = 0, n = 0, quiet = 0;
  logic [7:0]  dbytes [256];
  logic        m_ready = 0, m_we = 0, m_busy = 0, m_done = 0, m_hold = 0, m_err = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [AW:0] m_words = '0;
  int          cyc_n = 0;

  always @(posedge clk) begin
    bit hs;
    int d, w;
    cyc_n++;
    hs = byte_valid && m_ready;
    m_we = 0;
    if (reset) begin
      loading = 0; fin = 0; errp = 0; nb = 0; quiet = 0;
      m_hold = 0; m_err = 0; m_waddr = '0; m_wdata = '0; m_words = '0;
    end else if (fin) begin
      fin = 0; m_hold = 0;
    end else if (errp) begin
      errp = 0; m_err = 1;
    end else if (!loading) begin
      if (start) begin
        loading = 1; nb = 0; quiet = 0; m_err = 0; m_words = '0; m_hold = 1;
      end
    end else if (hs) begin
      quiet = 0;
      if (nb == 0) begin
        if (int'(byte_data) > NW) begin
          loading = 0; errp = 1;
        end else begin
          n = (byte_data == 8'd0) ? NW : int'(byte_data);
          nb = 1;
        end
      end else begin
        d = nb - 1;
        dbytes[d] = byte_data;
        nb++;
        if (d % 4 == 3) begin
          w = d / 4;
          m_we = 1;
          m_waddr = AW'(w);
          m_wdata = {dbytes[d], dbytes[d-1], dbytes[d-2], dbytes[d-3]};
          m_words = (AW+1)'(w + 1);
          if (w + 1 == n) begin
            loading = 0; fin = 1;
          end
        end
      end
    end else begin
      quiet++;
      if (quiet == TO) begin
        loading = 0; errp = 1;
      end
    end
    m_ready = loading;
    m_busy = loading;
    m_done = fin;
  end

  bit chk_en = 0;
  int ndone = 0;
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  int            wc [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_ready", byte_ready, m_ready);
      chk("imem_we", imem_we, m_we);
      chk("imem_waddr", imem_waddr, m_waddr);
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("cpu_hold", cpu_hold, m_hold);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("words_loaded", words_loaded, m_words);
      if (imem_we === 1'b1) begin
        wa.push_back(imem_waddr);
        wd.push_back(imem_wdata);
        wc.push_back(cyc_n);
      end
      if (done === 1'b1) ndone++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input int gmax, input int sp, output bit ok);
    bit got;
    bit fin_loop;
    ok = 0;
    fin_loop = 0;
    byte_valid = 1'b0;
    if (gmax > 0) repeat ($urandom_range(gmax, 0)) cyc();
    byte_valid = 1'b1;
    byte_data = b;
    for (int k = 0; k < 64 && !fin_loop; k++) begin
      start = (sp > 0) && ($urandom_range(sp - 1, 0) == 0);
      @(negedge clk);
      got = byte_ready;
      if (!got && !busy) begin
        start = 1'b0;
        fin_loop = 1;
      end else begin
        cyc();
        start = 1'b0;
        if (got) begin
          ok = 1;
          fin_loop = 1;
        end
      end
    end
    if (!fin_loop) chk("handshake_bound", 32'd1, 32'd0);
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic do_load(input int hdr, input int nbytes, input int gmax, input int sp);
    bit ok;
    start = 1'b1;
    cyc();
    start = 1'b0;
    send(8'(hdr), gmax, 0, ok);
    for (int i = 0; i < nbytes && ok; i++) send(8'($urandom), gmax, sp, ok);
  endtask

  initial begin
    logic [7:0] p1 [9];
    bit ok;
    int base, dbase, viol, hn, nbt, kind;
    p1 = '{8'h02, 8'h1f, 8'h20, 8'h03, 8'hd5, 8'h0a, 8'h3c, 8'h00, 8'h91};

    cyc();
    chk_en = 1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_we", imem_we, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", byte_ready, 0);

    // Directed: two-instruction image.
    base = wa.size(); dbase = ndone;
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_hold_on", cpu_hold, 1);
    for (int i = 0; i < 9; i++) send(p1[i], 0, 0, ok);
    repeat (3) cyc();
    chk("t1_nwr", wa.size() - base, 2);
    chk("t1_a0", wa[base], 0);
    chk("t1_d0", wd[base], 32'hd503201f);
    chk("t1_a1", wa[base+1], 1);
    chk("t1_d1", wd[base+1], 32'h91003c0a);
    chk("t1_done", ndone - dbase, 1);
    chk("t1_words", words_loaded, 2);
    chk("t1_hold_off", cpu_hold, 0);

    // Directed: full 64-word image, back to back.
    base = wa.size();
    do_load(0, 256, 0, 0);
    repeat (3) cyc();
    chk("t2_nwr", wa.size() - base, 64);
    chk("t2_last", wa[base+63], 63);
    viol = 0;
    for (int i = 1; i < 64; i++) if (wc[base+i] - wc[base+i-1] != 4) viol++;
    chk("t2_spacing", viol, 0);
    chk("t2_words", words_loaded, 64);

    // Directed: oversize header, then start clears err.
    base = wa.size();
    do_load(8'h41, 0, 0, 0);
    repeat (3) cyc();
    chk("t3_err", err, 1);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_nwr", wa.size() - base, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t3_err_clr", err, 0);

    // Directed: timeout mid-word from the HDR entered above.
    send(8'h01, 0, 0, ok);
    send(8'haa, 0, 0, ok);
    send(8'hbb, 0, 0, ok);
    repeat (TO + 3) cyc();
    chk("t4_err", err, 1);
    chk("t4_nwr", wa.size() - base, 0);
    chk("t4_hold", cpu_hold, 1);

    // Directed: reset after 3 of 5 words.
    base = wa.size();
    do_load(5, 13, 0, 0);
    chk("t5_nwr", wa.size() - base, 3);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t5_we", imem_we, 0);
    chk("t5_hold", cpu_hold, 0);
    chk("t5_words", words_loaded, 0);
    chk("t5_wdata", imem_wdata, 0);
    chk("t5_busy", busy, 0);
    repeat (5) cyc();
    chk("t5_nwr_after", wa.size() - base, 3);

    // Directed: start pulsed on every DATA byte.
    base = wa.size(); dbase = ndone;
    do_load(3, 12, 0, 1);
    repeat (3) cyc();
    chk("t6_nwr", wa.size() - base, 3);
    chk("t6_done", ndone - dbase, 1);
    chk("t6_words", words_loaded, 3);

    // Random loads.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(9, 0);
      if (kind <= 6) begin
        hn = $urandom_range(NW, 0);
        nbt = ((hn == 0) ? NW : hn) * 4;
        do_load(hn, nbt, $urandom_range(2, 0), ($urandom_range(1, 0) == 1) ? 8 : 0);
      end else if (kind == 7) begin
        do_load($urandom_range(255, NW + 1), 0, 0, 0);
      end else if (kind == 8) begin
        hn = $urandom_range(8, 1);
        do_load(hn, $urandom_range(hn * 4 - 1, 0), 1, 0);
        repeat (TO + 4) cyc();
      end else begin
        hn = $urandom_range(10, 2);
        do_load(hn, $urandom_range(hn * 4 - 1, 0), 1, 0);
        reset = 1'b1; cyc(); reset = 1'b0;
      end
      repeat (3) cyc();
    end

    repeat (5) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
